sw_time_counter: RTL and testbench

Stopwatch time-keeping stage directly downstream of the divided-tick generator. Runs on the gated stopwatch clock `sub_clk`, detects rising edges of the divided tick, and advances a BCD MM:SS.t count (tenths of a second up to 59:59.9). Includes a lap-hold display freeze, synchronous clear, and an overflow pulse. Outputs feed the seven-segment display mux.

---
 rtl/sw_pkg.sv | 20 ++
 rtl/sw_bcd_digit.sv | 29 ++
 rtl/sw_time_counter.sv | 127 ++++++++++++
 tb/tb_sw_time_counter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared widths, digit limits and lap FSM encoding for the stopwatch time counter.
package sw_pkg;

   localparam int BCD_W           = 4;
   localparam int DIGIT_MAX_9     = 9;
   localparam int DIGIT_MAX_5     = 5;
   localparam int SYNC_STAGES_DEF = 2;

   typedef enum logic [0:0] {LIVE = 1'b0, HELD = 1'b1} lap_state_e;

   // Digit order is tenths, sec-ones, sec-tens, min-ones, min-tens.
   function automatic int digit_max(input int idx, input int min_tens_max);
      case (idx)
         2:       return DIGIT_MAX_5;
         4:       return min_tens_max;
         default: return DIGIT_MAX_9;
      endcase
   endfunction

endpackage

// File: rtl/sw_bcd_digit.sv
// One BCD counter digit that wraps after MAX and reports a carry to the next digit.
module sw_bcd_digit
   import sw_pkg::*;
#(
   parameter int MAX = DIGIT_MAX_9
) (
   input  logic             sub_clk,
   input  logic             rst,
   input  logic             en,
   input  logic             clr,
   output logic [BCD_W-1:0] q,
   output logic             at_max,
   output logic             carry
);

   assign at_max = (q == BCD_W'(MAX));
   assign carry  = en & at_max;

   always_ff @(posedge sub_clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= at_max ? '0 : q + 1'b1;
      end
   end

endmodule

// File: rtl/sw_time_counter.sv
// Stopwatch MM:SS.t BCD counter with tick edge detect, clear, overflow pulse and an
// optional lap display freeze enabled by defining SW_LAP_EN.
module sw_time_counter
   import sw_pkg::*;
#(
   parameter int MIN_TENS_MAX = DIGIT_MAX_5,
   parameter int SYNC_STAGES  = SYNC_STAGES_DEF
) (
   input  logic             sub_clk,
   input  logic             rst,
   input  logic             tick_in,
   input  logic             clr,
   input  logic             lap,
   output logic [BCD_W-1:0] d_tenth,
   output logic [BCD_W-1:0] d_sec0,
   output logic [BCD_W-1:0] d_sec1,
   output logic [BCD_W-1:0] d_min0,
   output logic [BCD_W-1:0] d_min1,
   output logic             lap_active,
   output logic             ovf
);

   logic                   tick_q;
   logic                   inc;
   logic [SYNC_STAGES-1:0] clr_sync;
   logic                   clr_s;
   logic [4:0]             en;
   logic [4:0]             carry;
   logic [4:0]             at_max_unused;
   logic [BCD_W-1:0]       live [5];
   logic [BCD_W-1:0]       disp [5];

   assign inc   = tick_in & ~tick_q;
   assign clr_s = clr_sync[SYNC_STAGES-1];
   assign en[0] = inc;

   for (genvar k = 0; k < 5; k++) begin : g_digit
      sw_bcd_digit #(.MAX(digit_max(k, MIN_TENS_MAX))) u_digit (
         .sub_clk (sub_clk),
         .rst     (rst),
         .en      (en[k]),
         .clr     (clr_s),
         .q       (live[k]),
         .at_max  (at_max_unused[k]),
         .carry   (carry[k])
      );
      if (k < 4) begin : g_link
         assign en[k+1] = carry[k];
      end
   end

   // The top carry only fires when every digit wraps, which is the overflow event.
   always_ff @(posedge sub_clk or negedge rst) begin
      if (!rst) begin
         tick_q   <= 1'b0;
         clr_sync <= '0;
         ovf      <= 1'b0;
      end else begin
         tick_q   <= tick_in;
         clr_sync <= {clr_sync[SYNC_STAGES-2:0], clr};
         ovf      <= carry[4] & ~clr_s;
      end
   end

`ifdef SW_LAP_EN
   localparam logic [0:0] ST_LIVE = LIVE;
   localparam logic [0:0] ST_HELD = HELD;

   logic [SYNC_STAGES-1:0] lap_sync;
   logic                   lap_d;
   logic                   lap_p;
   logic [0:0]             state;
   logic [BCD_W-1:0]       hold [5];

   assign lap_p = lap_sync[SYNC_STAGES-1] & ~lap_d;

   // Latching live[] on lap_p captures the pre-increment value when a tick coincides.
   always_ff @(posedge sub_clk or negedge rst) begin
      if (!rst) begin
         lap_sync <= '0;
         lap_d    <= 1'b0;
         state    <= ST_LIVE;
         hold     <= '{default: '0};
      end else begin
         lap_sync <= {lap_sync[SYNC_STAGES-2:0], lap};
         lap_d    <= lap_sync[SYNC_STAGES-1];
         if (clr_s) begin
            state <= ST_LIVE;
            hold  <= '{default: '0};
         end else if (lap_p) begin
            if (state == ST_LIVE) begin
               state <= ST_HELD;
               hold  <= live;
            end else begin
               state <= ST_LIVE;
            end
         end
      end
   end

   assign lap_active = (state == ST_HELD);

   always_comb begin
      for (int k = 0; k < 5; k++) begin
         disp[k] = lap_active ? hold[k] : live[k];
      end
   end
`else
   logic lap_unused;

   assign lap_unused = lap;
   assign lap_active = 1'b0;

   always_comb begin
      for (int k = 0; k < 5; k++) begin
         disp[k] = live[k];
      end
   end
`endif

   assign d_tenth = disp[0];
   assign d_sec0  = disp[1];
   assign d_sec1  = disp[2];
   assign d_min0  = disp[3];
   assign d_min1  = disp[4];

endmodule

// File: tb/tb_sw_time_counter.sv
// Bench for sw_time_counter: a tenths-count reference model feeds an expected queue
// that a negedge monitor drains against the DUT every cycle. Define SW_LAP_EN to match the DUT build.
module tb_sw_time_counter;

   // A single minutes-tens step keeps the wrap test short while still exercising that digit.
   localparam int TB_MIN_TENS = 1;
   localparam int TB_SYNC     = 2;
   localparam int MAX_T       = (TB_MIN_TENS + 1) * 6000;

   logic       sub_clk;
   logic       rst;
   logic       tick_in;
   logic       clr;
   logic       lap;
   logic [3:0] d_tenth, d_sec0, d_sec1, d_min0, d_min1;
   logic       lap_active;
   logic       ovf;

   int n_cmp = 0;
   int n_err = 0;

   logic [21:0] exp_q[$];
   logic [21:0] mon_exp;
   logic [21:0] mon_act;

   int cnt;
   int hold_cnt;
   bit held;
   bit m_ovf;
   bit tick_prev;
   bit clr_hist[$];
   bit lap_hist[$];

   sw_time_counter #(
      .MIN_TENS_MAX (TB_MIN_TENS),
      .SYNC_STAGES  (TB_SYNC)
   ) dut (
      .sub_clk    (sub_clk),
      .rst        (rst),
      .tick_in    (tick_in),
      .clr        (clr),
      .lap        (lap),
      .d_tenth    (d_tenth),
      .d_sec0     (d_sec0),
      .d_sec1     (d_sec1),
      .d_min0     (d_min0),
      .d_min1     (d_min1),
      .lap_active (lap_active),
      .ovf        (ovf)
   );

   initial sub_clk = 1'b0;
   always #5 sub_clk = ~sub_clk;

   function automatic logic [19:0] to_bcd(input int t);
      int s;
      int m;
      s = (t / 10) % 60;
      m = t / 600;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(t % 10)};
   endfunction

   function automatic logic [21:0] actual();
      return {lap_active, ovf, d_min1, d_min0, d_sec1, d_sec0, d_tenth};
   endfunction

   function automatic logic [21:0] model_out();
      return {held, m_ovf, to_bcd(held ? hold_cnt : cnt)};
   endfunction

   function automatic void model_reset();
      cnt = 0;
      hold_cnt = 0;
      held = 1'b0;
      m_ovf = 1'b0;
      tick_prev = 1'b0;
      clr_hist.delete();
      lap_hist.delete();
      for (int i = 0; i < TB_SYNC + 2; i++) begin
         clr_hist.push_back(1'b0);
         lap_hist.push_back(1'b0);
      end
   endfunction

   // Buttons act TB_SYNC edges after being sampled; a lap acts on its rising edge only.
   function automatic void model_edge(input bit t, input bit c, input bit l);
      bit inc_e;
      bit clr_e;
      clr_hist.push_front(c);
      lap_hist.push_front(l);
      if (clr_hist.size() > TB_SYNC + 2) void'(clr_hist.pop_back());
      if (lap_hist.size() > TB_SYNC + 2) void'(lap_hist.pop_back());
      clr_e = clr_hist[TB_SYNC];
      inc_e = t & ~tick_prev;
      tick_prev = t;
      m_ovf = 1'b0;
      if (clr_e) begin
         cnt = 0;
         hold_cnt = 0;
         held = 1'b0;
      end else begin
`ifdef SW_LAP_EN
         if (lap_hist[TB_SYNC] && !lap_hist[TB_SYNC+1]) begin
            if (!held) hold_cnt = cnt;
            held = !held;
         end
`endif
         if (inc_e) begin
            if (cnt == MAX_T - 1) begin
               cnt = 0;
               m_ovf = 1'b1;
            end else begin
               cnt++;
            end
         end
      end
   endfunction

   // One modelled clock edge per call; returns on the following negedge.
   task automatic step(input bit t, input bit c, input bit l);
      tick_in = t;
      clr = c;
      lap = l;
      @(posedge sub_clk);
      model_edge(t, c, l);
      exp_q.push_back(model_out());
      @(negedge sub_clk);
   endtask

   task automatic tick_once();
      step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic press_lap();
      step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b1);
      repeat (TB_SYNC + 2) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic press_clr();
      step(1'b0, 1'b1, 1'b0);
      repeat (TB_SYNC + 1) step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic check(input string name, input logic [21:0] exp);
      n_cmp++;
      if (actual() !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, actual(), exp);
      end
   endtask

   always @(negedge sub_clk) begin
      if (exp_q.size() > 0) begin
         mon_exp = exp_q.pop_front();
         mon_act = actual();
         n_cmp++;
         if (mon_act !== mon_exp) begin
            n_err++;
            $display("FAIL cycle_check @%0t: got %h expected %h", $time, mon_act, mon_exp);
         end
      end
   end

   initial begin
      rst = 1'b0;
      tick_in = 1'b0;
      clr = 1'b0;
      lap = 1'b0;
      model_reset();
      repeat (2) @(posedge sub_clk);
      @(negedge sub_clk);
      check("reset", 22'h0);
      rst = 1'b1;

      repeat (10) tick_once();
      check("ten_ticks", 22'h00010);

      repeat (20) step(1'b1, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0);
      check("tick_held_high", 22'h00011);

      while (cnt != MAX_T - 1) tick_once();
      check("at_max", 22'h19599);
      step(1'b1, 1'b0, 1'b0);
      check("wrap_ovf", 22'h100000);
      step(1'b0, 1'b0, 1'b0);
      check("ovf_one_cycle", 22'h0);

      repeat (32) tick_once();
      press_lap();
      repeat (7) tick_once();
`ifdef SW_LAP_EN
      check("lap_hold", 22'h200032);
`else
      check("lap_ignored", 22'h000039);
`endif
      press_lap();
      check("lap_release", 22'h000039);

      press_clr();
      repeat (125) tick_once();
      press_lap();
`ifdef SW_LAP_EN
      check("held_12_5", 22'h200125);
`else
      check("live_12_5", 22'h000125);
`endif
      step(1'b0, 1'b1, 1'b0);
      repeat (TB_SYNC) step(1'b0, 1'b0, 1'b0);
      check("clr_in_held", 22'h0);

      repeat (5) tick_once();
      step(1'b0, 1'b1, 1'b0);
      repeat (TB_SYNC - 1) step(1'b0, 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0);
      check("clr_with_tick", 22'h0);
      step(1'b0, 1'b0, 1'b0);

      repeat (800) begin
         step(1'($urandom_range(0, 1)), ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 9) == 0));
      end
      repeat (6) step(1'b0, 1'b0, 1'b0);

      press_clr();
      repeat (456) tick_once();
      press_lap();
      #2 rst = 1'b0;
      #1 check("async_reset", 22'h0);
      model_reset();
      @(posedge sub_clk);
      @(negedge sub_clk);
      rst = 1'b1;
      repeat (3) tick_once();
      check("post_reset", 22'h00003);

      #1;
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
